// File: rtl/ct_ifu_tag_pkg.sv
// Shared types and sizes for the IFU tag SRAM access controller.
package ct_ifu_tag_pkg;

  localparam int TAG_ADDR_WIDTH = 8;
  localparam int TAG_DATA_WIDTH = 23;
  localparam int TAG_VLD_BIT    = 22;

  typedef enum logic [1:0] {
    RST  = 2'b00,
    INIT = 2'b01,
    IDLE = 2'b10,
    INV  = 2'b11
  } tag_state_e;

endpackage

// File: rtl/ct_ifu_tag_sweep_cnt.sv
// Sweep index counter shared by the post-reset init sweep and invalidate-all.
module ct_ifu_tag_sweep_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             last,
  output logic             wrap
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = &cnt;
  // Wrap happens naturally on the increment past the last index.
  assign wrap = en & last;

endmodule

// File: rtl/ct_ifu_tag_sram_ctrl.sv
// Single-port IFU tag SRAM access controller: zeroing sweep, write-over-read arbitration, read return.
// Optional build macro CT_IFU_TAGCTRL_RDHOLD_EN keeps the last read value on rd_data between reads.
module ct_ifu_tag_sram_ctrl
  import ct_ifu_tag_pkg::*;
#(
  parameter int ADDR_WIDTH = TAG_ADDR_WIDTH,
  parameter int DATA_WIDTH = TAG_DATA_WIDTH
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  inv_req,
  output logic                  inv_busy,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_grant,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  rd_grant,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output tag_state_e            dbg_state
);

  // Handshake: a requester holds req (and its idx/data/mask) until it sees grant
  // high in the same cycle; grant is combinational and only ever given in IDLE.

  tag_state_e            state;
  logic [ADDR_WIDTH-1:0] swp_cnt;
  logic                  swp_last;
  logic                  swp_wrap;
  logic                  sweeping;
  logic                  idle;
  logic                  sweep_start;

  assign sweeping    = (state == INIT) || (state == INV);
  assign idle        = (state == IDLE);
  assign sweep_start = idle & inv_req;
  assign inv_busy    = ~idle;
  assign dbg_state   = state;

  ct_ifu_tag_sweep_cnt #(
    .WIDTH (ADDR_WIDTH)
  ) u_sweep_cnt (
    .clk   (forever_cpuclk),
    .rst_n (cpurst_b),
    .start (sweep_start),
    .en    (sweeping),
    .cnt   (swp_cnt),
    .last  (swp_last),
    .wrap  (swp_wrap)
  );

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state <= RST;
    end else begin
      case (state)
        RST:     state <= INIT;
        INIT:    if (swp_wrap) state <= IDLE;
        INV:     if (swp_wrap) state <= IDLE;
        IDLE:    if (inv_req) state <= INV;
        default: state <= RST;
      endcase
    end
  end

  // The IDLE cycle that takes inv_req still serves its port request.
  always_comb begin
    wr_grant  = 1'b0;
    rd_grant  = 1'b0;
    sram_a    = '0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_d    = '0;
    if (sweeping) begin
      sram_a    = swp_cnt;
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
    end else if (idle) begin
      if (wr_req) begin
        wr_grant  = 1'b1;
        sram_a    = wr_idx;
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = ~wr_mask;
        sram_d    = wr_data;
      end else if (rd_req) begin
        rd_grant  = 1'b1;
        sram_a    = rd_idx;
        sram_cen  = 1'b0;
      end
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= rd_grant;
    end
  end

`ifdef CT_IFU_TAGCTRL_RDHOLD_EN
  logic [DATA_WIDTH-1:0] rd_hold;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_hold <= '0;
    end else if (sweep_start) begin
      rd_hold <= '0;
    end else if (rd_vld) begin
      rd_hold <= sram_q;
    end
  end

  assign rd_data = rd_vld ? sram_q : rd_hold;
`else
  assign rd_data = rd_vld ? sram_q : '0;
`endif

  logic unused_ok;
  assign unused_ok = swp_last;

endmodule

// File: tb/tb_ct_ifu_tag_sram_ctrl.sv
// Bench for ct_ifu_tag_sram_ctrl: behavioural tag SRAM, reference array, read-return scoreboard.
module tb_ct_ifu_tag_sram_ctrl;
  import ct_ifu_tag_pkg::*;

  localparam int AW    = TAG_ADDR_WIDTH;
  localparam int DW    = TAG_DATA_WIDTH;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          cpurst_b;
  logic          inv_req;
  logic          inv_busy;
  logic          wr_req;
  logic [AW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] wr_mask;
  logic          wr_grant;
  logic          rd_req;
  logic [AW-1:0] rd_idx;
  logic          rd_grant;
  logic          rd_vld;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;
  tag_state_e    dbg_state;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit seeded = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] sram_mem [DEPTH];

  always #5 clk = ~clk;

  ct_ifu_tag_sram_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (cpurst_b),
    .inv_req        (inv_req),
    .inv_busy       (inv_busy),
    .wr_req         (wr_req),
    .wr_idx         (wr_idx),
    .wr_data        (wr_data),
    .wr_mask        (wr_mask),
    .wr_grant       (wr_grant),
    .rd_req         (rd_req),
    .rd_idx         (rd_idx),
    .rd_grant       (rd_grant),
    .rd_vld         (rd_vld),
    .rd_data        (rd_data),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q),
    .dbg_state      (dbg_state)
  );

  // Tag SRAM macro model; contents start as garbage so the sweep has to zero them.
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] <= DW'($urandom);
      seeded <= 1'b1;
    end else if (!sram_cen) begin
      if (!sram_gwen) begin
        sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      end else begin
        sram_q <= sram_mem[sram_a];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Read-return scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_vld) begin
        if (exp_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
        else check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
      end else begin
        check("rd_data_zero", 64'(rd_data), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_check(input int exp_len, input bit with_rst);
    int n;
    int idx;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (!inv_busy) break;
      if (with_rst && n == 0) begin
        check("rst_cycle_pins", 64'({sram_cen, sram_gwen, sram_a}), 64'({1'b1, 1'b1, 8'h00}));
      end else begin
        idx = n - (with_rst ? 1 : 0);
        check("sweep_pins", 64'({sram_a, sram_cen, sram_gwen, sram_wen, sram_d}),
              64'({idx[7:0], 1'b0, 1'b0, 23'h0, 23'h0}));
      end
      n++;
    end
    check("busy_len", 64'(n), 64'(exp_len));
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] idx, input logic [DW-1:0] data,
                          input logic [DW-1:0] mask);
    wr_req = 1'b1; wr_idx = idx; wr_data = data; wr_mask = mask;
    @(negedge clk);
    check("wr_grant", 64'({wr_grant, rd_grant}), 64'(2'b10));
    check("wr_pins", 64'({sram_a, sram_cen, sram_gwen, sram_wen, sram_d}),
          64'({idx, 1'b0, 1'b0, ~mask, data}));
    ref_mem[idx] = (ref_mem[idx] & ~mask) | (data & mask);
    tick();
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] idx);
    rd_req = 1'b1; rd_idx = idx;
    @(negedge clk);
    check("rd_grant", 64'({wr_grant, rd_grant}), 64'(2'b01));
    check("rd_pins", 64'({sram_a, sram_cen, sram_gwen, sram_wen}),
          64'({idx, 1'b0, 1'b1, {DW{1'b1}}}));
    exp_q.push_back(ref_mem[idx]);
    tick();
    rd_req = 1'b0;
  endtask

  // Both requesters at once: write wins, read is served on the following cycle.
  task automatic do_both(input logic [AW-1:0] widx, input logic [DW-1:0] data,
                         input logic [DW-1:0] mask, input logic [AW-1:0] ridx);
    wr_req = 1'b1; wr_idx = widx; wr_data = data; wr_mask = mask;
    rd_req = 1'b1; rd_idx = ridx;
    @(negedge clk);
    check("both_grant", 64'({wr_grant, rd_grant, sram_gwen, sram_a}), 64'({1'b1, 1'b0, 1'b0, widx}));
    ref_mem[widx] = (ref_mem[widx] & ~mask) | (data & mask);
    tick();
    wr_req = 1'b0;
    @(negedge clk);
    check("both_rd_grant", 64'({wr_grant, rd_grant, sram_a}), 64'({1'b0, 1'b1, ridx}));
    exp_q.push_back(ref_mem[ridx]);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle_pins", 64'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d, wr_grant, rd_grant}),
          64'({1'b1, 1'b1, {DW{1'b1}}, 8'h00, 23'h0, 1'b0, 1'b0}));
    tick();
  endtask

  initial begin
    int w;
    int op;
    cpurst_b = 1'b0; inv_req = 1'b0;
    wr_req = 1'b0; wr_idx = '0; wr_data = '0; wr_mask = '0;
    rd_req = 1'b0; rd_idx = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("rst_sram", 64'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
          64'({1'b1, 1'b1, {DW{1'b1}}, 8'h00, 23'h0}));
    check("rst_ctl", 64'({wr_grant, rd_grant, rd_vld, rd_data, inv_busy}),
          64'({1'b0, 1'b0, 1'b0, 23'h0, 1'b1}));

    cpurst_b = 1'b1;
    sweep_check(257, 1'b1);
    check("state_idle", 64'(dbg_state), 64'(IDLE));
    tick();
    idle_cycle();

    do_read(8'h37);
    do_write(8'h37, 23'h4A5A5A, {DW{1'b1}});
    do_read(8'h37);
    do_write(8'h37, 23'h000003, 23'h00000F);
    do_read(8'h37);
    do_write(8'h37, 23'h7FFFFF, 23'h0);
    do_read(8'h37);
    do_both(8'h10, 23'h123456, {DW{1'b1}}, 8'h37);
    do_read(8'h10);

    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: do_write(AW'($urandom_range(0, 15)), DW'($urandom), DW'($urandom));
        1: do_read(AW'($urandom_range(0, 15)));
        2: do_both(AW'($urandom_range(0, 15)), DW'($urandom), DW'($urandom),
                   AW'($urandom_range(0, 15)));
        default: idle_cycle();
      endcase
    end

    // Invalidate-all raised together with a read: the read still goes through.
    inv_req = 1'b1; rd_req = 1'b1; rd_idx = 8'h37;
    @(negedge clk);
    check("inv_cycle_rd", 64'({rd_grant, inv_busy}), 64'({1'b1, 1'b0}));
    exp_q.push_back(ref_mem[8'h37]);
    tick();
    inv_req = 1'b0; rd_req = 1'b0;
    fork
      sweep_check(256, 1'b0);
      begin
        repeat (50) @(posedge clk);
        #1;
        inv_req = 1'b1; wr_req = 1'b1; wr_idx = 8'h37; wr_mask = '1; wr_data = 23'h1;
        rd_req = 1'b1;
        @(negedge clk);
        check("busy_grant", 64'({wr_grant, rd_grant}), 64'd0);
        tick();
        inv_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      end
    join
    tick();
    do_read(8'h37);
    do_read(8'h05);
    do_read(8'hFF);

    // Reset in the middle of a sweep.
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (sram_a != 8'd100 && w < 300);
    check("reach_idx100", 64'(sram_a), 64'd100);
    cpurst_b = 1'b0;
    #1;
    check("midrst_sram", 64'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
          64'({1'b1, 1'b1, {DW{1'b1}}, 8'h00, 23'h0}));
    check("midrst_ctl", 64'({wr_grant, rd_grant, rd_vld, rd_data, inv_busy}),
          64'({1'b0, 1'b0, 1'b0, 23'h0, 1'b1}));
    @(posedge clk);
    #1;
    cpurst_b = 1'b1;
    sweep_check(257, 1'b1);
    tick();
    do_read(8'h37);
    do_read(8'd120);
    do_read(8'd200);

    repeat (3) tick();
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
